// File: rtl/l2_arbiter_if.sv
// Bundles the two L1 miss ports and the L2 line port of the L2 arbiter.
// Handshake: a requester raises read/write with a stable address and holds it until its
// one-cycle resp; the L2 sees level strobes and answers with a one-cycle mem_resp.
interface l2_arbiter_if #(
    parameter int s_line = 256
);
    logic [31:0]       i_address;
    logic              i_read;
    logic [s_line-1:0] i_rdata;
    logic              i_resp;

    logic [31:0]       d_address;
    logic              d_read;
    logic              d_write;
    logic [s_line-1:0] d_wdata;
    logic [s_line-1:0] d_rdata;
    logic              d_resp;

    logic [31:0]       mem_address;
    logic              mem_read;
    logic              mem_write;
    logic [s_line-1:0] mem_wdata;
    logic [s_line-1:0] mem_rdata;
    logic              mem_resp;

    // Arbiter view
    modport slave (
        input  i_address, i_read, d_address, d_read, d_write, d_wdata, mem_rdata, mem_resp,
        output i_rdata, i_resp, d_rdata, d_resp, mem_address, mem_read, mem_write, mem_wdata
    );

    // Requester / L2 model view
    modport master (
        output i_address, i_read, d_address, d_read, d_write, d_wdata, mem_rdata, mem_resp,
        input  i_rdata, i_resp, d_rdata, d_resp, mem_address, mem_read, mem_write, mem_wdata
    );
endinterface

// File: rtl/l2_arbiter.sv
// Round-robin arbiter sharing one L2 line port between the L1 I-cache and D-cache,
// one outstanding transaction at a time, with a RELEASE cycle after every response.
module l2_arbiter #(
    parameter int s_offset = 5,
    parameter int s_line   = 256
) (
    input  logic        clk,
    input  logic        rst,
    l2_arbiter_if.slave bus,
    output logic        busy,
    output logic [1:0]  state_dbg
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2,
        RELEASE = 2'd3
    } state_t;

    localparam logic [31:0] off_mask = (32'd1 << s_offset) - 32'd1;

    state_t            state;
    state_t            state_next;
    logic              last_grant;   // 0 = I, 1 = D
    logic [31:0]       req_addr;
    logic [s_line-1:0] req_wdata;
    logic              req_op;       // 0 = read, 1 = write
    logic              grant_valid;
    logic              grant_d;
    logic              i_req;
    logic              d_req;
    logic              serving;

    assign i_req = bus.i_read;
    assign d_req = bus.d_read | bus.d_write;

    always_comb begin
        state_next  = state;
        grant_valid = 1'b0;
        grant_d     = 1'b0;
        case (state)
            IDLE: begin
                if (i_req && d_req) begin
                    grant_valid = 1'b1;
                    grant_d     = ~last_grant;
                end else if (i_req) begin
                    grant_valid = 1'b1;
                end else if (d_req) begin
                    grant_valid = 1'b1;
                    grant_d     = 1'b1;
                end
                if (grant_valid) state_next = grant_d ? SERVE_D : SERVE_I;
            end
            SERVE_I, SERVE_D: begin
                if (bus.mem_resp) state_next = RELEASE;
            end
            RELEASE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            req_addr   <= '0;
            req_wdata  <= '0;
            req_op     <= 1'b0;
        end else begin
            state <= state_next;
            if (grant_valid) begin
                last_grant <= grant_d;
                req_addr   <= (grant_d ? bus.d_address : bus.i_address) & ~off_mask;
                // read+write together from the D-cache resolves to a write
                req_op     <= grant_d & bus.d_write;
                req_wdata  <= grant_d ? bus.d_wdata : '0;
            end
        end
    end

    assign serving         = (state == SERVE_I) || (state == SERVE_D);
    assign bus.mem_address = req_addr;
    assign bus.mem_wdata   = req_wdata;
    assign bus.mem_read    = serving & ~req_op;
    assign bus.mem_write   = serving & req_op;
    assign bus.i_resp      = (state == SERVE_I) & bus.mem_resp;
    assign bus.d_resp      = (state == SERVE_D) & bus.mem_resp;
    assign bus.i_rdata     = bus.mem_rdata;
    assign bus.d_rdata     = bus.mem_rdata;
    assign busy            = (state != IDLE);
    assign state_dbg       = state;
endmodule

// File: tb/tb_l2_arbiter.sv
// Directed bench for l2_arbiter: reset, lone I read, D writeback, read+write,
// tie alternation and abort by reset.
module tb_l2_arbiter;
    localparam int s_line = 256;

    logic       clk;
    logic       rst;
    logic       busy;
    logic [1:0] state_dbg;
    int         checks;
    int         errors;

    l2_arbiter_if #(.s_line(s_line)) bus ();

    l2_arbiter #(.s_offset(5), .s_line(s_line)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .busy      (busy),
        .state_dbg (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {mem_read, mem_write, i_resp, d_resp, busy}
    function automatic logic [4:0] flags();
        return {bus.mem_read, bus.mem_write, bus.i_resp, bus.d_resp, busy};
    endfunction

    task automatic test_reset();
        logic [4:0] f;
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        f = flags();
        checks++;
        if (f !== 5'b00000 || bus.mem_address !== 32'h0 || bus.mem_wdata !== '0 || state_dbg !== 2'd0) begin
            errors++;
            $display("FAIL reset_outputs: flags=%b addr=%h state=%0d want flags=00000 addr=0 state=0",
                     f, bus.mem_address, state_dbg);
        end
        @(negedge clk) rst = 1'b1;
        for (int c = 0; c < 10; c++) begin
            bus.mem_resp = (c == 3 || c == 4);
            @(negedge clk);
            f = flags();
            checks++;
            if (f !== 5'b00000) begin
                errors++;
                $display("FAIL idle_cycle_%0d: flags=%b want 00000", c, f);
            end
        end
        bus.mem_resp = 1'b0;
    endtask

    task automatic test_lone_i_read();
        logic [s_line-1:0] pat;
        logic [4:0]        f;
        pat = {32{8'hA5}};
        @(posedge clk);
        #1;
        bus.i_read    = 1'b1;
        bus.i_address = 32'h0000_1234;
        @(negedge clk);
        checks++;
        if (flags() !== 5'b00000) begin
            errors++;
            $display("FAIL lone_i_before_grant: flags=%b want 00000", flags());
        end
        for (int c = 1; c <= 3; c++) begin
            @(posedge clk);
            #1;
            if (c == 3) begin
                bus.mem_resp  = 1'b1;
                bus.mem_rdata = pat;
            end
            @(negedge clk);
            f = flags();
            checks++;
            if (f !== ((c == 3) ? 5'b10101 : 5'b10001) || bus.mem_address !== 32'h0000_1220
                || bus.mem_wdata !== '0) begin
                errors++;
                $display("FAIL lone_i_cycle_%0d: flags=%b addr=%h want flags=%b addr=00001220 wdata=0",
                         c, f, bus.mem_address, (c == 3) ? 5'b10101 : 5'b10001);
            end
        end
        checks++;
        if (bus.i_rdata !== pat) begin
            errors++;
            $display("FAIL lone_i_rdata: got %h want %h", bus.i_rdata, pat);
        end
        @(posedge clk);
        #1;
        bus.mem_resp = 1'b0;
        bus.i_read   = 1'b0;
        @(negedge clk);
        checks++;
        if (flags() !== 5'b00001 || state_dbg !== 2'd3) begin
            errors++;
            $display("FAIL lone_i_release: flags=%b state=%0d want flags=00001 state=3", flags(), state_dbg);
        end
        @(negedge clk);
        checks++;
        if (flags() !== 5'b00000) begin
            errors++;
            $display("FAIL lone_i_back_idle: flags=%b want 00000", flags());
        end
    endtask

    task automatic test_d_writeback();
        logic [s_line-1:0] wd;
        logic [4:0]        f;
        wd = {8{32'h1122_3344}};
        @(posedge clk);
        #1;
        bus.d_write   = 1'b1;
        bus.d_address = 32'h8000_0040;
        bus.d_wdata   = wd;
        for (int c = 1; c <= 3; c++) begin
            @(posedge clk);
            #1;
            if (c == 2) begin
                bus.d_address = 32'h1234_5678;
                bus.d_wdata   = {8{32'hDEAD_BEEF}};
            end
            if (c == 3) begin
                bus.mem_resp  = 1'b1;
                bus.mem_rdata = {8{32'h0BAD_F00D}};
            end
            @(negedge clk);
            f = flags();
            checks++;
            if (f !== ((c == 3) ? 5'b01011 : 5'b01001) || bus.mem_address !== 32'h8000_0040
                || bus.mem_wdata !== wd) begin
                errors++;
                $display("FAIL d_wb_cycle_%0d: flags=%b addr=%h wdata=%h want flags=%b addr=80000040 wdata=%h",
                         c, f, bus.mem_address, bus.mem_wdata, (c == 3) ? 5'b01011 : 5'b01001, wd);
            end
        end
        @(posedge clk);
        #1;
        bus.mem_resp = 1'b0;
        bus.d_write  = 1'b0;
        @(negedge clk);
        checks++;
        if (flags() !== 5'b00001 || state_dbg !== 2'd3) begin
            errors++;
            $display("FAIL d_wb_release: flags=%b state=%0d want flags=00001 state=3", flags(), state_dbg);
        end
        @(negedge clk);
    endtask

    task automatic test_read_write_both();
        @(posedge clk);
        #1;
        bus.d_read    = 1'b1;
        bus.d_write   = 1'b1;
        bus.d_address = 32'h0000_007F;
        bus.d_wdata   = {8{32'h5555_AAAA}};
        @(posedge clk);
        #1;
        bus.mem_resp = 1'b1;
        @(negedge clk);
        checks++;
        if (flags() !== 5'b01011 || bus.mem_address !== 32'h0000_0060) begin
            errors++;
            $display("FAIL rd_wr_both: flags=%b addr=%h want flags=01011 addr=00000060",
                     flags(), bus.mem_address);
        end
        @(posedge clk);
        #1;
        bus.mem_resp = 1'b0;
        bus.d_read   = 1'b0;
        bus.d_write  = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_back_to_back_tie();
        logic [4:0]        exp_f;
        logic [31:0]       exp_a;
        logic [1:0]        exp_s;
        logic [s_line-1:0] pat;
        @(negedge clk) rst = 1'b0;
        @(negedge clk);
        rst           = 1'b1;
        bus.i_read    = 1'b1;
        bus.i_address = 32'h0000_2007;
        bus.d_read    = 1'b1;
        bus.d_address = 32'h0000_303F;
        for (int k = 0; k < 4; k++) begin
            exp_f = (k % 2 == 0) ? 5'b10101 : 5'b10011;
            exp_a = (k % 2 == 0) ? 32'h0000_2000 : 32'h0000_3020;
            exp_s = (k % 2 == 0) ? 2'd1 : 2'd2;
            pat   = {8{32'hC0DE_0000 + 32'(k)}};
            @(posedge clk);
            #1;
            bus.mem_resp  = 1'b1;
            bus.mem_rdata = pat;
            @(negedge clk);
            checks++;
            if (flags() !== exp_f || bus.mem_address !== exp_a || state_dbg !== exp_s) begin
                errors++;
                $display("FAIL tie_txn_%0d: flags=%b addr=%h state=%0d want flags=%b addr=%h state=%0d",
                         k, flags(), bus.mem_address, state_dbg, exp_f, exp_a, exp_s);
            end
            @(posedge clk);
            #1;
            bus.mem_resp = 1'b0;
            @(negedge clk);
            checks++;
            if (flags() !== 5'b00001 || state_dbg !== 2'd3) begin
                errors++;
                $display("FAIL tie_release_%0d: flags=%b state=%0d want flags=00001 state=3",
                         k, flags(), state_dbg);
            end
            if (k == 3) begin
                bus.i_read = 1'b0;
                bus.d_read = 1'b0;
            end
            @(negedge clk);
            checks++;
            if (flags() !== 5'b00000 || state_dbg !== 2'd0) begin
                errors++;
                $display("FAIL tie_idle_%0d: flags=%b state=%0d want flags=00000 state=0",
                         k, flags(), state_dbg);
            end
        end
    endtask

    task automatic test_abort();
        @(posedge clk);
        #1;
        bus.i_read    = 1'b1;
        bus.i_address = 32'h4444_4444;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (flags() !== 5'b10001 || bus.mem_address !== 32'h4444_4440) begin
            errors++;
            $display("FAIL abort_pre: flags=%b addr=%h want flags=10001 addr=44444440",
                     flags(), bus.mem_address);
        end
        #1 bus.mem_resp = 1'b1;
        #1 rst = 1'b0;
        #1;
        checks++;
        if (flags() !== 5'b00000 || bus.mem_address !== 32'h0) begin
            errors++;
            $display("FAIL abort_drop: flags=%b addr=%h want flags=00000 addr=0", flags(), bus.mem_address);
        end
        bus.mem_resp = 1'b0;
        bus.i_read   = 1'b0;
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;
        bus.i_read    = 1'b1;
        bus.i_address = 32'h0000_ABCD;
        for (int c = 1; c <= 2; c++) begin
            @(posedge clk);
            #1;
            if (c == 2) begin
                bus.mem_resp  = 1'b1;
                bus.mem_rdata = {8{32'h7777_8888}};
            end
            @(negedge clk);
            checks++;
            if (flags() !== ((c == 2) ? 5'b10101 : 5'b10001) || bus.mem_address !== 32'h0000_ABC0) begin
                errors++;
                $display("FAIL abort_fresh_cycle_%0d: flags=%b addr=%h want flags=%b addr=0000abc0",
                         c, flags(), bus.mem_address, (c == 2) ? 5'b10101 : 5'b10001);
            end
        end
        @(posedge clk);
        #1;
        bus.mem_resp = 1'b0;
        bus.i_read   = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst           = 1'b0;
        bus.i_address = '0;
        bus.i_read    = 1'b0;
        bus.d_address = '0;
        bus.d_read    = 1'b0;
        bus.d_write   = 1'b0;
        bus.d_wdata   = '0;
        bus.mem_rdata = '0;
        bus.mem_resp  = 1'b0;
        #12 rst = 1'b1;
        test_reset();
        test_lone_i_read();
        test_d_writeback();
        test_read_write_both();
        test_back_to_back_tie();
        test_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/l2_arbiter.md
# l2_arbiter

- Arbitrates one L2 cache line port between the L1 instruction cache and the L1 data cache.
- Latches the winning request, presents it to the L2 with the offset bits cleared, holds it until the L2 responds, and routes the response back to the winner only.
- Round-robin on simultaneous requests; one outstanding L2 transaction at a time.
- Sits between both L1 miss ports and the L2 cache's mem_* port.

## Interface
- s_offset, 5, line offset bits; outgoing address bits [s_offset-1:0] forced to 0
- s_line, 256, line width in bits
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-low reset
- i_address  in  32  instruction-cache miss address
- i_read  in  1  instruction-cache line read request
- i_rdata  out  s_line  line data to instruction cache
- i_resp  out  1  one-cycle completion to instruction cache
- d_address  in  32  data-cache miss/writeback address
- d_read  in  1  data-cache line read request
- d_write  in  1  data-cache line write (writeback) request
- d_wdata  in  s_line  writeback line data
- d_rdata  out  s_line  line data to data cache
- d_resp  out  1  one-cycle completion to data cache
- mem_address  out  32  address to L2
- mem_read  out  1  L2 read strobe
- mem_write  out  1  L2 write strobe
- mem_wdata  out  s_line  L2 write data
- mem_rdata  in  s_line  L2 read data
- mem_resp  in  1  L2 completion
- busy  out  1  high in any state other than IDLE

## Operation
- State register: IDLE, SERVE_I, SERVE_D, RELEASE.
- Registers: last_grant (0=I, 1=D), req_addr, req_wdata, req_op (read/write).
- IDLE, no request: stay in IDLE.
- IDLE, only I requesting: grant I, go to SERVE_I.
- IDLE, only D requesting (d_read or d_write): grant D, go to SERVE_D.
- IDLE, both requesting: grant the port not equal to last_grant.
- On grant:
  - latch the address with bits [s_offset-1:0] cleared, plus op and wdata (I: op=read, wdata=0);
  - set last_grant to the granted port.
- SERVE_x:
  - mem_address=req_addr; mem_read = (op==read); mem_write = (op==write); mem_wdata=req_wdata.
  - All are driven from registers, so requester inputs changing mid-transaction have no effect.
- SERVE_x with mem_resp=1:
  - assert x_resp combinationally in that cycle; the other port's resp stays 0;
  - go to RELEASE.
- RELEASE: mem_read=mem_write=0, no sampling of requests; go to IDLE next cycle. This absorbs the requester's request, still high in the resp cycle.
- d_read and d_write both high: treated as a write. This combination is illegal for the D-cache; the rule exists only to make behaviour deterministic.
- i_rdata and d_rdata: continuous copies of mem_rdata; valid only when the matching resp is high.
- Requester contract:
  - hold request and address stable until its resp;
  - drop the request in the cycle after resp, or raise a new one from IDLE.
- mem_resp outside SERVE_x: ignored.

## Timing
- Reset (rst=0, asynchronous, effective immediately):
  - state=IDLE, last_grant=1 (first tie goes to I);
  - req_addr=0, req_wdata=0;
  - mem_read=mem_write=0, mem_address=0, mem_wdata=0;
  - i_resp=d_resp=0, busy=0.
- Reset during SERVE_x aborts the transaction without a resp; the L2 strobe drops the same instant.
- Request seen in IDLE at edge t: mem_read/mem_write high from t+1.
- L2 responding k cycles after strobe: requester resp in the same cycle as mem_resp.
- Back-to-back minimum: one L2 transaction per (L2 latency + 2) cycles (IDLE and RELEASE each cost one cycle).
- Strobes are level: high every cycle of SERVE_x, low in IDLE and RELEASE.
- A request arriving during SERVE_x or RELEASE waits. It is evaluated at the first IDLE cycle, against the updated last_grant.
- Starvation bound: a waiting port is granted within one foreign transaction.

## Test plan
- Reset then idle:
  - rst=0 mid-cycle → all outputs 0 immediately;
  - release with no requests for 10 cycles → busy=0, no strobes.
- Lone I read:
  - i_read=1, i_address=0x0000_1234, L2 resp after 3 cycles with mem_rdata=0xA5…A5;
  - → mem_address=0x0000_1220, mem_read=1 for 3 cycles, i_resp=1 with i_rdata=0xA5…A5, d_resp=0.
- D writeback:
  - d_write=1, d_address=0x8000_0040, d_wdata=0x1122…;
  - → mem_write=1, mem_wdata=0x1122…, mem_read=0, d_resp on mem_resp, then one RELEASE cycle with strobes low.
- Simultaneous requests after reset:
  - i_read and d_read both high → I served first, D granted at the IDLE after I's RELEASE.
  - Repeat the tie → D then I (alternation).
- Input change mid-transaction: d_address changed during SERVE_D → mem_address unchanged.
- Abort: rst=0 during SERVE_I → mem_read drops immediately, no i_resp; after release, a fresh i_read completes normally.
